// File: rtl/tile_scheduler.sv
// Command sequencer in front of tile_processor: walks a tile grid in row-major
// order, issuing one start per tile and reporting completion, progress and errors.
module tile_scheduler #(
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_ni,
  input  logic [2:0] cmd_nj,
  output logic       cmd_done,
  output logic       cmd_err,
  output logic       busy,
  output logic [6:0] tiles_done,
  output logic       tp_start,
  output logic [2:0] tp_tile_i,
  output logic [2:0] tp_tile_j,
  output logic [2:0] tp_op_code,
  input  logic       tp_done
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } state_t;

  state_t        state;
  logic [2:0]    op;
  logic [2:0]    ni;
  logic [2:0]    nj;
  logic [CW-1:0] tcount;
  logic          row_col;
  logic          last_col;
  logic          last_tile;
  logic          timed_out;

  // tp_tile_i/tp_tile_j double as the traversal indices; only MUL and DOT walk columns.
  assign row_col   = (op == 3'd0) || (op == 3'd4);
  assign last_col  = !row_col || (tp_tile_j == nj);
  assign last_tile = last_col && (tp_tile_i == ni);
  assign timed_out = (TIMEOUT != 0) && (tcount == CW'(TIMEOUT - 1));

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op         <= '0;
      ni         <= '0;
      nj         <= '0;
      tcount     <= '0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
      tiles_done <= '0;
      tp_start   <= 1'b0;
      tp_tile_i  <= '0;
      tp_tile_j  <= '0;
      tp_op_code <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op         <= cmd_op;
            ni         <= cmd_ni;
            nj         <= cmd_nj;
            tiles_done <= '0;
            tcount     <= '0;
            tp_tile_i  <= '0;
            tp_tile_j  <= '0;
            if (cmd_op > 3'd4) begin
              cmd_done <= 1'b1;
              cmd_err  <= 1'b1;
              state    <= FINISH;
            end else begin
              tp_start   <= 1'b1;
              tp_op_code <= cmd_op;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          tp_start <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (tp_done) begin
            tiles_done <= tiles_done + 7'd1;
            tcount     <= '0;
            if (last_tile) begin
              cmd_done <= 1'b1;
              cmd_err  <= 1'b0;
              state    <= FINISH;
            end else begin
              if (last_col) begin
                tp_tile_j <= '0;
                tp_tile_i <= tp_tile_i + 3'd1;
              end else begin
                tp_tile_j <= tp_tile_j + 3'd1;
              end
              tp_start <= 1'b1;
              state    <= ISSUE;
            end
          end else if (timed_out) begin
            cmd_done <= 1'b1;
            cmd_err  <= 1'b1;
            state    <= FINISH;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        FINISH: begin
          cmd_done <= 1'b0;
          cmd_err  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
